// File: rtl/gemm_tile_drain.sv
// Drains one RowPar x ColPar GeMM output tile as a single-element valid/ready stream
// with flat row-major C addresses, skipping edge positions. Define GEMM_TILE_DRAIN_DBUF_EN for a pending second tile buffer.
module gemm_tile_drain #(
  parameter int unsigned OutDataWidth  = 32,
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  tile_we_i,
  input  logic [RowPar*ColPar*OutDataWidth-1:0] tile_data_i,
  input  logic [SizeAddrWidth-1:0]              tile_row_base_i,
  input  logic [SizeAddrWidth-1:0]              tile_col_base_i,
  input  logic [SizeAddrWidth-1:0]              M_size_i,
  input  logic [SizeAddrWidth-1:0]              N_size_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [OutDataWidth-1:0]               out_data_o,
  output logic [AddrWidth-1:0]                  out_addr_o,
  output logic                                  out_last_o,
  output logic                                  busy_o,
  output logic                                  overflow_o
);

  localparam int unsigned RowW = (RowPar > 1) ? $clog2(RowPar) : 1;
  localparam int unsigned ColW = (ColPar > 1) ? $clog2(ColPar) : 1;
  localparam int unsigned SumW = SizeAddrWidth + 1;
  localparam logic [RowW-1:0] RowMax = RowW'(RowPar - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(ColPar - 1);

  typedef logic [RowPar-1:0][ColPar-1:0][OutDataWidth-1:0] tile_data_t;

  typedef struct packed {
    tile_data_t               data;
    logic [SizeAddrWidth-1:0] row_base;
    logic [SizeAddrWidth-1:0] col_base;
    logic [SizeAddrWidth-1:0] m_size;
    logic [SizeAddrWidth-1:0] n_size;
  } tile_ctx_t;

  typedef enum logic {
    StIdle,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  tile_ctx_t       cur_q;
  tile_ctx_t       new_ctx;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic            overflow_q;

  logic [SumW-1:0]      row_abs, col_abs;
  logic [AddrWidth-1:0] addr_c;
  logic row_in, col_in, row_end, col_end, elem_in, pos_last;
  logic draining, advance, tile_done;
  logic take_in, drop, next_tile, held;

  assign new_ctx = {tile_data_i, tile_row_base_i, tile_col_base_i, M_size_i, N_size_i};

  // Position of the cursor in C and its bounds status
  assign row_abs  = SumW'(cur_q.row_base) + SumW'(row_q);
  assign col_abs  = SumW'(cur_q.col_base) + SumW'(col_q);
  assign row_in   = row_abs < SumW'(cur_q.m_size);
  assign col_in   = col_abs < SumW'(cur_q.n_size);
  assign row_end  = (row_q == RowMax) || ((row_abs + SumW'(1)) >= SumW'(cur_q.m_size));
  assign col_end  = (col_q == ColMax) || ((col_abs + SumW'(1)) >= SumW'(cur_q.n_size));
  assign elem_in  = row_in && col_in;
  assign pos_last = (row_q == RowMax) && (col_q == ColMax);
  assign addr_c   = AddrWidth'(row_abs) * AddrWidth'(cur_q.n_size) + AddrWidth'(col_abs);

  assign draining  = (state_q == StDrain);
  assign advance   = draining && (!elem_in || out_ready_i);
  assign tile_done = advance && pos_last;

`ifdef GEMM_TILE_DRAIN_DBUF_EN
  tile_ctx_t pend_q;
  logic      pend_v_q;
  logic      take_pend, fill_pend;

  // A finishing tile frees the active slot, so the pending slot may be refilled in that same cycle
  assign take_in   = tile_we_i && (!draining || (tile_done && !pend_v_q));
  assign take_pend = tile_done && pend_v_q;
  assign fill_pend = tile_we_i && draining && (tile_done ? pend_v_q : !pend_v_q);
  assign drop      = tile_we_i && draining && !tile_done && pend_v_q;
  assign next_tile = tile_we_i || pend_v_q;
  assign held      = draining || pend_v_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else if (fill_pend) begin
      pend_q   <= new_ctx;
      pend_v_q <= 1'b1;
    end else if (take_pend) begin
      pend_v_q <= 1'b0;
    end
  end
`else
  assign take_in   = tile_we_i && (!draining || tile_done);
  assign drop      = tile_we_i && draining && !tile_done;
  assign next_tile = tile_we_i;
  assign held      = draining;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q <= '0;
    end else if (take_in) begin
      cur_q <= new_ctx;
`ifdef GEMM_TILE_DRAIN_DBUF_EN
    end else if (take_pend) begin
      cur_q <= pend_q;
`endif
    end
  end

  // Row-major cursor; wraps to (0,0) on the final position so a follow-on tile starts clean
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance) begin
      if (col_q == ColMax) begin
        col_q <= '0;
        row_q <= (row_q == RowMax) ? '0 : row_q + RowW'(1);
      end else begin
        col_q <= col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (tile_we_i) state_d = StDrain;
      StDrain: if (tile_done && !next_tile) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stream outputs are zero unless the cursor sits on an in-range element
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_addr_o  = '0;
    out_last_o  = 1'b0;
    busy_o      = held;
    overflow_o  = overflow_q;
    if (draining && elem_in) begin
      out_valid_o = 1'b1;
      out_data_o  = cur_q.data[row_q][col_q];
      out_addr_o  = addr_c;
      out_last_o  = row_end && col_end;
    end
  end

endmodule

// File: tb/tb_gemm_tile_drain.sv
// Randomised and directed bench for gemm_tile_drain against a queue-based model of the
// expected element stream (row-major scan of the in-range tile rectangle).
module tb_gemm_tile_drain;

  localparam int RP = 4;
  localparam int CP = 16;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               tile_we_i = 1'b0;
  logic [RP*CP*DW-1:0] tile_data_i = '0;
  logic [SW-1:0]      tile_row_base_i = '0, tile_col_base_i = '0, M_size_i = '0, N_size_i = '0;
  logic               out_valid_o, out_ready_i = 1'b1, out_last_o, busy_o, overflow_o;
  logic [DW-1:0]      out_data_o;
  logic [AW-1:0]      out_addr_o;

  gemm_tile_drain dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .tile_we_i(tile_we_i), .tile_data_i(tile_data_i),
    .tile_row_base_i(tile_row_base_i), .tile_col_base_i(tile_col_base_i),
    .M_size_i(M_size_i), .N_size_i(N_size_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_addr_o(out_addr_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t        exp_q[$];
  logic [DW-1:0] td [RP][CP];
  int checks = 0, errors = 0;
  int cyc = 0, beats = 0, first_cyc = -1, last_cyc = -1, fall_cyc = -1, idle_busy = 0;
  int t_issue = 0, t_a = 0, rmode = 0;
  logic [AW-1:0] first_addr = '0;
  logic s_busy = 1'b0, hold_pend = 1'b0, h_last = 1'b0;
  logic [DW-1:0] h_data = '0;
  logic [AW-1:0] h_addr = '0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock cycle: sample and compare at the falling edge, then drive ready after the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (hold_pend) begin
      checks++;
      if (!(out_valid_o && out_data_o == h_data && out_addr_o == h_addr && out_last_o == h_last)) begin
        errors++;
        $display("FAIL hold cyc=%0d got v=%0b d=%h a=%0d l=%0b want v=1 d=%h a=%0d l=%0b",
                 cyc, out_valid_o, out_data_o, out_addr_o, out_last_o, h_data, h_addr, h_last);
      end
    end
    if (!out_valid_o) begin
      checks++;
      if (out_data_o != '0 || out_last_o) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d got d=%h l=%0b want d=0 l=0", cyc, out_data_o, out_last_o);
      end
    end
    if (out_valid_o && out_ready_i) begin
      if (beats == 0) begin
        first_cyc  = cyc;
        first_addr = out_addr_o;
      end
      beats++;
      if (out_last_o) last_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat cyc=%0d got unexpected a=%0d d=%h want none", cyc, out_addr_o, out_data_o);
      end else begin
        e = exp_q.pop_front();
        if (out_addr_o != e.addr || out_data_o != e.data || out_last_o != e.last) begin
          errors++;
          $display("FAIL beat cyc=%0d got a=%0d d=%h l=%0b want a=%0d d=%h l=%0b",
                   cyc, out_addr_o, out_data_o, out_last_o, e.addr, e.data, e.last);
        end
      end
    end
    if (busy_o && !out_valid_o) idle_busy++;
    if (s_busy && !busy_o) fall_cyc = cyc;
    s_busy    = busy_o;
    hold_pend = out_valid_o && !out_ready_i;
    h_data    = out_data_o;
    h_addr    = out_addr_o;
    h_last    = out_last_o;
    @(posedge clk_i);
    #1;
    case (rmode)
      0:       out_ready_i = 1'b1;
      1:       out_ready_i = ~out_ready_i;
      default: out_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clr();
    beats = 0; first_cyc = -1; last_cyc = -1; fall_cyc = -1; idle_busy = 0;
  endtask

  task automatic fill_idx();
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) td[r][c] = DW'(r * CP + c);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) td[r][c] = $urandom;
  endtask

  // Reference: every (r,c) of the tile that lands inside the MxN matrix, in row-major order
  task automatic model_push(input int rb, input int cb, input int m, input int n);
    exp_t e;
    int   cnt = 0;
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++)
        if (rb + r < m && cb + c < n) begin
          e.addr = AW'((rb + r) * n + cb + c);
          e.data = td[r][c];
          e.last = 1'b0;
          exp_q.push_back(e);
          cnt++;
        end
    if (cnt > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input int rb, input int cb, input int m, input int n, input bit accept);
    logic [RP-1:0][CP-1:0][DW-1:0] p;
    for (int r = 0; r < RP; r++)
      for (int c = 0; c < CP; c++) p[r][c] = td[r][c];
    tile_data_i     = p;
    tile_row_base_i = SW'(rb);
    tile_col_base_i = SW'(cb);
    M_size_i        = SW'(m);
    N_size_i        = SW'(n);
    tile_we_i       = 1'b1;
    if (accept) model_push(rb, cb, m, n);
    step();
    tile_we_i = 1'b0;
    t_issue   = cyc;
  endtask

  task automatic drain_wait();
    int k = 0;
    do begin
      step();
      k++;
    end while ((exp_q.size() != 0 || s_busy) && k < 2000);
    chk("drain_timeout", longint'(k >= 2000), 0);
    chk("drain_leftover", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < 500) begin
      step();
      k++;
    end
    chk("wait_beats", beats, n);
  endtask

  initial begin
    exp_t e0, e3, e4, e7;
    bit   dbuf;
`ifdef GEMM_TILE_DRAIN_DBUF_EN
    dbuf = 1'b1;
`else
    dbuf = 1'b0;
`endif
    step();
    step();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_addr", out_addr_o, 0);
    chk("rst_last", out_last_o, 0);
    rst_ni = 1'b1;
    step();

    // Full 4x16 tile, ready held high
    rmode = 0; clr(); fill_idx();
    issue(0, 0, 4, 16, 1'b1);
    chk("t1_model_n", exp_q.size(), 64);
    e0 = exp_q[0]; e7 = exp_q[63];
    chk("t1_model_a0", e0.addr, 0);
    chk("t1_model_a63", e7.addr, 63);
    chk("t1_model_d63", e7.data, 63);
    chk("t1_model_l63", e7.last, 1);
    drain_wait();
    chk("t1_beats", beats, 64);
    chk("t1_first", first_cyc, t_issue + 1);
    chk("t1_last", last_cyc, t_issue + 64);
    chk("t1_busyfall", fall_cyc, t_issue + 65);
    chk("t1_ovf", overflow_o, 0);

    // Edge tile: only a 2x4 corner is inside a 6x20 matrix
    clr(); fill_rand();
    issue(4, 16, 6, 20, 1'b1);
    e0 = exp_q[0]; e3 = exp_q[3]; e4 = exp_q[4]; e7 = exp_q[7];
    chk("t2_model_n", exp_q.size(), 8);
    chk("t2_model_a0", e0.addr, 96);
    chk("t2_model_a3", e3.addr, 99);
    chk("t2_model_a4", e4.addr, 116);
    chk("t2_model_a7", e7.addr, 119);
    chk("t2_model_l7", e7.last, 1);
    drain_wait();
    chk("t2_beats", beats, 8);
    chk("t2_last", last_cyc, t_issue + 20);
    chk("t2_skips", idle_busy, 56);
    chk("t2_busyfall", fall_cyc, t_issue + 65);

    // Toggling ready
    rmode = 1; clr(); fill_idx();
    issue(0, 0, 4, 16, 1'b1);
    drain_wait();
    chk("t3_beats", beats, 64);

    // Second tile mid-drain, then a third
    rmode = 0; out_ready_i = 1'b1; clr(); fill_rand();
    issue(0, 0, 4, 16, 1'b1);
    t_a = t_issue;
    wait_beats(10);
    fill_rand();
    issue(0, 0, 4, 16, dbuf);
    repeat (4) step();
    fill_rand();
    issue(0, 0, 4, 16, 1'b0);
    drain_wait();
    chk("t4_ovf", overflow_o, 1);
    chk("t4_beats", beats, dbuf ? 128 : 64);
    chk("t4_busyfall", fall_cyc, t_a + (dbuf ? 129 : 65));

    // Asynchronous reset mid-drain
    clr(); fill_rand();
    issue(0, 0, 4, 16, 1'b1);
    wait_beats(20);
    rst_ni = 1'b0;
    #1;
    chk("t5_valid", out_valid_o, 0);
    chk("t5_busy", busy_o, 0);
    exp_q.delete();
    hold_pend = 1'b0;
    s_busy = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    clr(); fill_rand();
    issue(0, 0, 4, 16, 1'b1);
    drain_wait();
    chk("t5_first_addr", first_addr, 0);
    chk("t5_beats", beats, 64);
    chk("t5_ovf", overflow_o, 0);

    // New tile coincident with the final handshake
    clr(); fill_rand();
    issue(0, 0, 4, 16, 1'b1);
    t_a = t_issue;
    repeat (63) step();
    fill_rand();
    issue(0, 0, 4, 16, 1'b1);
    drain_wait();
    chk("t6_ovf", overflow_o, 0);
    chk("t6_beats", beats, 128);
    chk("t6_last", last_cyc, t_a + 128);
    chk("t6_busyfall", fall_cyc, t_a + 129);

    // Random tiles, bounds and ready patterns
    for (int i = 0; i < 30; i++) begin
      int rb, cb, m, n;
      rmode = $urandom_range(0, 2);
      out_ready_i = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        rb = $urandom_range(240, 255); cb = $urandom_range(230, 255); m = 255; n = 255;
      end else begin
        rb = $urandom_range(0, 12); cb = $urandom_range(0, 40);
        m = $urandom_range(0, 16); n = $urandom_range(0, 60);
      end
      clr(); fill_rand();
      issue(rb, cb, m, n, 1'b1);
      drain_wait();
      if (rmode == 0) chk("rand_busyfall", fall_cyc, t_issue + 65);
    end
    chk("end_ovf", overflow_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
